// File: rtl/cache_mem_ctrl_pkg.sv
// cache_mem_ctrl_pkg: shared RAM/word types and controller state encoding for the cache memory controller.
package cache_mem_ctrl_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_IRD  = 2'd1;
    localparam logic [1:0] ST_DRD  = 2'd2;
    localparam logic [1:0] ST_DWR  = 2'd3;
    typedef enum logic [1:0] {IDLE = ST_IDLE, IRD = ST_IRD, DRD = ST_DRD, DWR = ST_DWR} mc_state_t;
    localparam int C_BLK_WORDS = 2;
endpackage

// File: rtl/cache_mem_ctrl_if.sv
// cache_mem_ctrl_if: cache request/response and RAM port bundle; master is the controller, slave the caches and RAM.
interface cache_mem_ctrl_if;
    import cache_mem_ctrl_pkg::*;
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dword;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dword, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dword, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: arbitrates icache word fetches and dcache two-word fills/writebacks onto one RAM port.
module cache_mem_ctrl
    import cache_mem_ctrl_pkg::*;
(
    input logic              CLK,
    input logic              nRST,
    cache_mem_ctrl_if.master mc
);
    mc_state_t state_q, state_d;
    logic      dword_q, dword_d;
    logic      last_q, last_d;
    logic      done, dreq, own, last_word;
    logic      unused_addr_bits;
    assign done      = mc.ramstate == ACCESS;
    assign dreq      = mc.dREN | mc.dWEN;
    assign own       = state_q == DWR ? mc.dWEN : state_q == DRD ? mc.dREN : mc.iREN;
    assign last_word = dword_q == 1'(C_BLK_WORDS - 1);
    assign unused_addr_bits = ^{mc.iaddr[1:0], mc.daddr[2:0]};
    assign mc.iload  = mc.ramload;
    assign mc.dload  = mc.ramload;
    assign mc.dword  = dword_q;
    // last_q = 1 means the dcache won the previous grant, so a contested IDLE goes to the icache
    always_comb begin
        state_d     = state_q;
        dword_d     = dword_q;
        last_d      = last_q;
        mc.ramREN   = 1'b0;
        mc.ramWEN   = 1'b0;
        mc.ramaddr  = '0;
        mc.ramstore = '0;
        mc.iwait    = 1'b1;
        mc.dwait    = 1'b1;
        if (state_q == IDLE) begin
            if (dreq && !(mc.iREN && last_q)) begin
                state_d = mc.dWEN ? DWR : DRD;
                dword_d = 1'b0;
                last_d  = 1'b1;
            end else if (mc.iREN) begin
                state_d = IRD;
                dword_d = 1'b0;
                last_d  = 1'b0;
            end
        end else if (!own) begin
            state_d = IDLE;
            dword_d = 1'b0;
        end else if (state_q == IRD) begin
            mc.ramREN  = 1'b1;
            mc.ramaddr = {mc.iaddr[31:2], 2'b00};
            mc.iwait   = !done;
            state_d    = done ? IDLE : state_q;
        end else begin
            mc.ramREN   = state_q == DRD;
            mc.ramWEN   = state_q == DWR;
            mc.ramaddr  = {mc.daddr[31:3], dword_q, 2'b00};
            mc.ramstore = state_q == DWR ? mc.dstore : '0;
            mc.dwait    = !done;
            dword_d     = done ? (last_word ? 1'b0 : dword_q + 1'b1) : dword_q;
            state_d     = done && last_word ? IDLE : state_q;
        end
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            dword_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dword_q <= dword_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_cache_mem_ctrl.sv
// tb_cache_mem_ctrl: directed stimulus with a completion scoreboard; the monitor pops one entry per iwait/dwait low cycle.
module tb_cache_mem_ctrl;
    import cache_mem_ctrl_pkg::*;
    typedef struct packed {
        logic  d;
        logic  wr;
        logic  w;
        word_t addr;
        word_t store;
        word_t load;
    } exp_t;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t m_e;
    cache_mem_ctrl_if bus ();
    cache_mem_ctrl dut (.CLK(CLK), .nRST(nRST), .mc(bus));
    always #5 CLK = ~CLK;
    task automatic chk(string nm, word_t act, word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask
    task automatic chk1(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask
    task automatic push(logic d, logic wr, logic w, word_t addr, word_t store, word_t load);
        sb.push_back(exp_t'{d, wr, w, addr, store, load});
    endtask
    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask
    task automatic idle_chk(string nm);
        @(negedge CLK);
        chk1({nm, "_ramREN"}, bus.ramREN, 1'b0);
        chk1({nm, "_ramWEN"}, bus.ramWEN, 1'b0);
        chk1({nm, "_iwait"}, bus.iwait, 1'b1);
        chk1({nm, "_dwait"}, bus.dwait, 1'b1);
        chk1({nm, "_dword"}, bus.dword, 1'b0);
        chk({nm, "_ramaddr"}, bus.ramaddr, 32'h0);
        chk({nm, "_ramstore"}, bus.ramstore, 32'h0);
    endtask
    always @(negedge CLK) begin
        if (bus.ramREN && bus.ramWEN) begin
            errors++;
            $display("FAIL strobes: ramREN=1 ramWEN=1 at ramaddr %h, required never both high", bus.ramaddr);
        end
        if (!bus.iwait || !bus.dwait) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: iwait %b dwait %b ramaddr %h, required no completion", bus.iwait, bus.dwait, bus.ramaddr);
            end else begin
                m_e = sb.pop_front();
                chk1("mon_iwait", bus.iwait, m_e.d);
                chk1("mon_dwait", bus.dwait, !m_e.d);
                chk("mon_ramaddr", bus.ramaddr, m_e.addr);
                chk1("mon_ramREN", bus.ramREN, !m_e.wr);
                chk1("mon_ramWEN", bus.ramWEN, m_e.wr);
                if (m_e.wr) chk("mon_ramstore", bus.ramstore, m_e.store);
                else chk("mon_load", m_e.d ? bus.dload : bus.iload, m_e.load);
                if (m_e.d) chk1("mon_dword", bus.dword, m_e.w);
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
    initial begin
        bus.iREN = 1'b1;
        bus.dREN = 1'b1;
        bus.dWEN = 1'b0;
        bus.iaddr = 32'h0;
        bus.daddr = 32'h0;
        bus.dstore = 32'h0;
        bus.ramload = 32'h0;
        bus.ramstate = ACCESS;
        step(2);
        idle_chk("reset");
        step();
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        nRST = 1'b1;
        step();
        idle_chk("post_reset");
        step();
        // icache fetch with two BUSY cycles before ACCESS
        bus.iaddr = 32'h0000_0046;
        bus.ramload = 32'hDEAD_BEEF;
        bus.ramstate = BUSY;
        bus.iREN = 1'b1;
        push(1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 32'hDEAD_BEEF);
        step();
        @(negedge CLK);
        chk("i_busy_ramaddr", bus.ramaddr, 32'h0000_0044);
        chk1("i_busy_iwait", bus.iwait, 1'b1);
        chk1("i_busy_ramREN", bus.ramREN, 1'b1);
        step(2);
        bus.ramstate = ACCESS;
        step();
        bus.iREN = 1'b0;
        bus.ramstate = FREE;
        idle_chk("i_after");
        step();
        // dcache fill, immediate ACCESS
        bus.daddr = 32'h0000_0104;
        bus.ramload = 32'h0BAD_F00D;
        bus.ramstate = ACCESS;
        bus.dREN = 1'b1;
        push(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'h0BAD_F00D);
        push(1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h0, 32'hCAFE_F00D);
        step(2);
        bus.ramload = 32'hCAFE_F00D;
        step();
        bus.dREN = 1'b0;
        idle_chk("dfill_after");
        step();
        // dcache writeback with an ERROR retry on word 1
        bus.daddr = 32'h0000_0208;
        bus.dstore = 32'h1111_1111;
        bus.dWEN = 1'b1;
        push(1'b1, 1'b1, 1'b0, 32'h0000_0208, 32'h1111_1111, 32'h0);
        push(1'b1, 1'b1, 1'b1, 32'h0000_020C, 32'h2222_2222, 32'h0);
        step(2);
        bus.dstore = 32'h2222_2222;
        bus.ramstate = ERROR;
        @(negedge CLK);
        chk1("wb_err_dwait", bus.dwait, 1'b1);
        chk1("wb_err_ramWEN", bus.ramWEN, 1'b1);
        chk1("wb_err_dword", bus.dword, 1'b1);
        chk("wb_err_ramaddr", bus.ramaddr, 32'h0000_020C);
        step();
        bus.ramstate = ACCESS;
        step();
        bus.dWEN = 1'b0;
        idle_chk("wb_after");
        step();
        // icache fetch with immediate ACCESS, leaves last-grant on the icache
        bus.iaddr = 32'h0000_0080;
        bus.ramload = 32'h55AA_55AA;
        bus.iREN = 1'b1;
        push(1'b0, 1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'h55AA_55AA);
        step(2);
        bus.iREN = 1'b0;
        step();
        // contested requests alternate: dcache block, icache word, dcache block
        bus.iaddr = 32'h0000_0010;
        bus.daddr = 32'h0000_0300;
        bus.ramload = 32'h1234_5678;
        bus.iREN = 1'b1;
        bus.dREN = 1'b1;
        push(1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'h1234_5678);
        push(1'b1, 1'b0, 1'b1, 32'h0000_0304, 32'h0, 32'h1234_5678);
        push(1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678);
        push(1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'h1234_5678);
        push(1'b1, 1'b0, 1'b1, 32'h0000_0304, 32'h0, 32'h1234_5678);
        step(5);
        bus.iREN = 1'b0;
        step(3);
        bus.dREN = 1'b0;
        idle_chk("arb_after");
        step();
        // dREN and dWEN together: writeback wins
        bus.daddr = 32'h0000_0400;
        bus.dstore = 32'h3333_3333;
        bus.dREN = 1'b1;
        bus.dWEN = 1'b1;
        push(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h3333_3333, 32'h0);
        push(1'b1, 1'b1, 1'b1, 32'h0000_0404, 32'h3333_3333, 32'h0);
        step(3);
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        step();
        // nRST pulsed mid-writeback, then the block restarts at word 0
        bus.daddr = 32'h0000_0500;
        bus.dstore = 32'h4444_4444;
        bus.dWEN = 1'b1;
        push(1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h4444_4444, 32'h0);
        step(2);
        bus.ramstate = BUSY;
        @(negedge CLK);
        chk1("rst_mid_dword", bus.dword, 1'b1);
        chk("rst_mid_ramaddr", bus.ramaddr, 32'h0000_0504);
        nRST = 1'b0;
        #1;
        chk1("rst_pulse_ramWEN", bus.ramWEN, 1'b0);
        chk1("rst_pulse_dword", bus.dword, 1'b0);
        chk1("rst_pulse_dwait", bus.dwait, 1'b1);
        chk("rst_pulse_ramaddr", bus.ramaddr, 32'h0);
        step();
        nRST = 1'b1;
        bus.ramstate = ACCESS;
        push(1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h4444_4444, 32'h0);
        push(1'b1, 1'b1, 1'b1, 32'h0000_0504, 32'h4444_4444, 32'h0);
        idle_chk("rst_release");
        step(3);
        bus.dWEN = 1'b0;
        step();
        // dWEN dropped after word 0 completes: no completion, back to IDLE, fresh block restarts at word 0
        bus.daddr = 32'h0000_0600;
        bus.dstore = 32'h6666_6666;
        bus.dWEN = 1'b1;
        push(1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h6666_6666, 32'h0);
        step(2);
        bus.dWEN = 1'b0;
        @(negedge CLK);
        chk1("drop_ramWEN", bus.ramWEN, 1'b0);
        chk1("drop_dwait", bus.dwait, 1'b1);
        step();
        idle_chk("drop_idle");
        step();
        bus.dWEN = 1'b1;
        push(1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h6666_6666, 32'h0);
        push(1'b1, 1'b1, 1'b1, 32'h0000_0604, 32'h6666_6666, 32'h0);
        step(3);
        bus.dWEN = 1'b0;
        step(2);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
